// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered UART transmitter with CTS/RTS flow control
//
// Ports:
//   clock_uart     in   bit-rate clock (one line bit per cycle)
//   reset          in   synchronous, active-low reset
//   tx_data        in   DATA_BITS-wide byte to queue
//   tx_data_valid  in   push request
//   tx_data_ready  out  FIFO not full
//   cts            in   peer clear-to-send, gates frame starts only
//   rts            out  registered: FIFO non-empty or frame in flight
//   tx             out  registered serial line, idle high
//   busy           out  registered: start bit through last stop bit
//   fifo_count     out  FIFO occupancy
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock_uart,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_data_valid,
    output logic                          tx_data_ready,
    input  logic                          cts,
    output logic                          rts,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 r_state;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [DATA_BITS-1:0]   r_shift;
    logic [IW-1:0]          r_bit_idx;
    logic                   r_stop_idx;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_rts;

    state_t                 w_state_next;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [IW-1:0]          w_bit_idx_next;
    logic                   w_stop_idx_next;
    logic                   w_tx_next;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_can_start;
    logic [CW-1:0]          w_count_next;

    // Push is judged on the current count, so a push while full is dropped
    // even when a pop frees a slot on the same edge.
    assign w_push       = tx_data_valid && (r_count != FULL);
    assign w_can_start  = (r_count != '0) && cts;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // The registered line value is computed from the next state, so r_tx
    // always reflects the bit of the state the FSM is currently in.
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_tx_next       = r_tx;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (w_can_start) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                w_state_next   = S_DATA;
                w_tx_next      = r_shift[0];
                w_shift_next   = r_shift >> 1;
                w_bit_idx_next = '0;
            end
            S_DATA: begin
                if (r_bit_idx == LAST_BIT) begin
                    w_state_next    = S_STOP;
                    w_tx_next       = 1'b1;
                    w_stop_idx_next = 1'b0;
                end else begin
                    w_tx_next      = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = r_bit_idx + IW'(1);
                end
            end
            S_STOP: begin
                w_tx_next = 1'b1;
                if (r_stop_idx == LAST_STOP) begin
                    if (w_can_start) begin
                        // Back-to-back frame: no idle cycle in between.
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_state_next = S_START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_stop_idx_next = r_stop_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock_uart) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_rts      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_tx       <= w_tx_next;
            r_count    <= w_count_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_rts      <= (w_count_next != '0) || (w_state_next != S_IDLE);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clock_uart) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    assign tx_data_ready = (r_count != FULL);
    assign rts           = r_rts;
    assign tx            = r_tx;
    assign busy          = r_busy;
    assign fifo_count    = r_count;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;

    logic       clock_uart = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       cts;
    logic       rts;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    always #5 clock_uart = ~clock_uart;

    uart_tx #(
        .DATA_BITS (DB),
        .STOP_BITS (SB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock_uart   (clock_uart),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .cts          (cts),
        .rts          (rts),
        .tx           (tx),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       e_tx;
        logic       e_busy;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t       tbl [12];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Reference model: queued bytes plus the list of line bits still to send.
    logic [7:0] m_q [$];
    logic       m_bits [$];
    logic       line_q [$];
    logic [7:0] dec_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic c, input logic r);
        logic       acc;
        logic       st;
        logic [7:0] b;
        if (!r) begin
            m_q.delete();
            m_bits.delete();
            return;
        end
        acc = v && (m_q.size() < DEPTH);
        // A frame may start when the line is idle or on its final stop bit.
        st  = (m_bits.size() <= 1) && (m_q.size() > 0) && c;
        if (m_bits.size() > 0) void'(m_bits.pop_front());
        if (st) begin
            b = m_q.pop_front();
            m_bits.push_back(1'b0);
            for (int i = 0; i < DB; i++) m_bits.push_back(b[i]);
            for (int i = 0; i < SB; i++) m_bits.push_back(1'b1);
        end
        if (acc) m_q.push_back(d);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic c, input logic r);
        logic e_tx;
        logic e_busy;
        @(negedge clock_uart);
        tx_data_valid = v;
        tx_data       = d;
        cts           = c;
        reset         = r;
        @(posedge clock_uart);
        model_edge(v, d, c, r);
        #1;
        line_q.push_back(tx);
        e_tx   = (m_bits.size() > 0) ? m_bits[0] : 1'b1;
        e_busy = (m_bits.size() > 0);
        chk("model_tx", tx, e_tx);
        chk("model_busy", busy, e_busy);
        chk("model_count", fifo_count, m_q.size());
        chk("model_ready", tx_data_ready, m_q.size() != DEPTH);
        chk("model_rts", rts, (m_q.size() > 0) || e_busy);
    endtask

    task automatic decode_line();
        int         i;
        logic [7:0] b;
        dec_q.delete();
        i = 0;
        b = '0;
        while (i < line_q.size()) begin
            if (line_q[i] == 1'b0 && (i + DB) < line_q.size()) begin
                for (int j = 0; j < DB; j++) b[j] = line_q[i + 1 + j];
                dec_q.push_back(b);
                i = i + 1 + DB + SB;
            end else begin
                i++;
            end
        end
    endtask

    logic [7:0] exp_b2b  [3] = '{8'h00, 8'hFF, 8'h3C};
    logic [7:0] exp_fill [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] exp_fill2[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        int cnt;
        int first_b;
        int last_b;
        int peak;
        int zeros;

        reset = 1'b0; tx_data_valid = 1'b0; tx_data = 8'h00; cts = 1'b1;

        // Reset held 3 edges with valid asserted: nothing queued, line idle.
        repeat (3) cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rts", rts, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", tx_data_ready, 1);
        line_q.delete();
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        zeros = 0;
        foreach (line_q[k]) if (line_q[k] == 1'b0) zeros++;
        chk("rst_no_frame", zeros, 0);

        // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1.
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0};
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].c, 1'b1);
            chk($sformatf("tbl_tx[%0d]", i), tx, tbl[i].e_tx);
            chk($sformatf("tbl_busy[%0d]", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl_cnt[%0d]", i), fifo_count, tbl[i].e_cnt);
            if (busy) cnt++;
        end
        chk("single_busy_len", cnt, 10);

        // Back-to-back: three contiguous frames, count peaks at 2.
        line_q.delete();
        cnt = 0; peak = 0; first_b = -1; last_b = -1;
        for (int i = 0; i < 34; i++) begin
            cyc(i < 3, (i < 3) ? exp_b2b[i] : 8'h00, 1'b1, 1'b1);
            if (fifo_count > peak) peak = fifo_count;
            if (busy) begin
                cnt++;
                if (first_b < 0) first_b = i;
                last_b = i;
            end
        end
        chk("b2b_peak", peak, 2);
        chk("b2b_busy_cycles", cnt, 30);
        chk("b2b_contiguous", last_b - first_b + 1, 30);
        decode_line();
        chk("b2b_frames", dec_q.size(), 3);
        for (int k = 0; k < 3; k++)
            if (k < dec_q.size()) chk($sformatf("b2b_byte[%0d]", k), dec_q[k], exp_b2b[k]);

        // FIFO full with cts low, then drain; repeat to exercise pointer wrap.
        for (int pass = 0; pass < 2; pass++) begin
            line_q.delete();
            for (int i = 0; i < 5; i++)
                cyc(1'b1, (pass == 0) ? 8'(i + 1) : ((i < 4) ? exp_fill2[i] : 8'hEE), 1'b0, 1'b1);
            chk("full_count", fifo_count, 4);
            chk("full_ready", tx_data_ready, 0);
            chk("full_rts", rts, 1);
            repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1);
            chk("full_tx_held", tx, 1);
            repeat (45) cyc(1'b0, 8'h00, 1'b1, 1'b1);
            decode_line();
            chk("full_frames", dec_q.size(), 4);
            for (int k = 0; k < 4; k++)
                if (k < dec_q.size())
                    chk($sformatf("full_byte[%0d][%0d]", pass, k), dec_q[k],
                        (pass == 0) ? exp_fill[k] : exp_fill2[k]);
            chk("full_drained", fifo_count, 0);
        end

        // CTS drops mid-frame: current frame completes, second waits.
        line_q.delete();
        cyc(1'b1, 8'h55, 1'b1, 1'b1);
        cyc(1'b1, 8'hAA, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        repeat (12) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("cts_idle_tx", tx, 1);
        chk("cts_idle_busy", busy, 0);
        chk("cts_idle_rts", rts, 1);
        chk("cts_idle_count", fifo_count, 1);
        decode_line();
        chk("cts_first_frames", dec_q.size(), 1);
        if (dec_q.size() > 0) chk("cts_first_byte", dec_q[0], 8'h55);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("cts_resume_tx", tx, 0);
        chk("cts_resume_busy", busy, 1);
        chk("cts_resume_count", fifo_count, 0);
        repeat (11) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        decode_line();
        chk("cts_all_frames", dec_q.size(), 2);
        if (dec_q.size() > 1) chk("cts_second_byte", dec_q[1], 8'hAA);

        // Reset during data bit 5 with a byte still queued.
        cyc(1'b1, 8'hC3, 1'b1, 1'b1);
        cyc(1'b1, 8'h5A, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("midrst_pre_busy", busy, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("midrst_tx", tx, 1);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rts", rts, 0);
        line_q.delete();
        repeat (15) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        zeros = 0;
        foreach (line_q[k]) if (line_q[k] == 1'b0) zeros++;
        chk("midrst_no_residual", zeros, 0);

        // Randomized traffic against the frame-level model.
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 299) != 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the LED actor's UART link, the counterpart of the existing receive path. It accepts bytes from fabric logic into a small FIFO and shifts them out on `tx` as 8N1-style frames: one start bit, LSB-first data, then stop bits. It advances one bit per `clock_uart` cycle, so `clock_uart` runs at the baud rate, as on the receive side. It honours the peer's clear-to-send before starting each frame and raises `rts` while data is pending.

## Interface
- `DATA_BITS`, default 8: data bits per frame, 5..8.
- `STOP_BITS`, default 1: stop-bit cycles per frame, 1..2.
- `FIFO_DEPTH`, default 4: byte buffer depth, power of two, minimum 2.
- `clock_uart`  in  1  bit-rate clock; the only clock.
- `reset`  in  1  synchronous, active-low reset; low at a `clock_uart` rising edge resets the block.
- `tx_data`  in  DATA_BITS  byte to queue.
- `tx_data_valid`  in  1  request to push `tx_data`.
- `tx_data_ready`  out  1  FIFO not full; push accepted when valid && ready at an edge.
- `cts`  in  1  peer permits transmission; sampled only when a frame is about to start.
- `rts`  out  1  registered; high while the FIFO is non-empty or a frame is in flight.
- `tx`  out  1  registered serial line, idle high.
- `busy`  out  1  registered; high from the start-bit cycle through the last stop-bit cycle.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset values** (after an edge with `reset`=0): `tx`=1, `busy`=0, `rts`=0, `fifo_count`=0, `tx_data_ready`=1, state IDLE. The FIFO is flushed.
- **FIFO:**
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
  - `tx_data_ready` = (count != FIFO_DEPTH).
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
- **State machine:** IDLE, START, DATA, STOP.
  - **IDLE:** if the FIFO is non-empty and `cts`=1, pop the head into the shift register and go to START. Otherwise `tx` stays 1.
  - **START:** `tx`=0 for one cycle, bit index = 0, then go to DATA.
  - **DATA:** `tx`=shift[0], shift right, index+1. After DATA_BITS cycles go to STOP.
  - **STOP:** `tx`=1 for STOP_BITS cycles. On the final stop cycle:
    - if the FIFO is non-empty and `cts`=1, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- **Flow control:**
  - `cts` only gates frame starts.
  - Deasserting `cts` mid-frame does not truncate the frame; the current frame completes.
  - `rts` = FIFO non-empty or `busy`, registered.
- **Reset mid-frame:** the frame is abandoned, `tx` returns to 1 at the reset edge, and queued bytes are lost.
- When DATA_BITS < 8, only `tx_data[DATA_BITS-1:0]` is used.

## Timing
- **Push-to-line latency:**
  - Byte pushed at edge n into an empty FIFO while IDLE with `cts`=1: pop at edge n+1, start bit on `tx` from n+1 to n+2.
  - Data bit i occupies cycle n+2+i.
  - Stop bits follow from n+2+DATA_BITS.
- **Frame length:** exactly 1+DATA_BITS+STOP_BITS cycles; default 10.
- **Continuous streaming:** throughput of one byte per frame length.
- **`busy`:** rises with the start bit and falls on the edge after the final stop bit, unless a back-to-back frame follows.
- **`fifo_count` on pop:** decrements on the edge that moves IDLE/STOP → START.
- **`cts` low while data is queued:** `tx` stays 1 and `rts` stays 1 indefinitely. The first edge with `cts`=1 starts a frame.

## Test plan
- **Reset:** hold `reset`=0 for 3 edges with `tx_data_valid`=1 → `tx`=1, `busy`=0, `rts`=0, `fifo_count`=0, no frame emitted.
- **Single byte:** push 0xA5 with `cts`=1 → `tx` sequence 0,1,0,1,0,0,1,0,1,1 starting one cycle after the push; `busy` high for 10 cycles.
- **Back-to-back:** push 0x00, 0xFF, 0x3C on consecutive edges → three contiguous 10-cycle frames with no idle cycle between them; `fifo_count` peaks at 2.
- **FIFO full:** hold `cts`=0 and push 5 bytes (0x01..0x05) → `fifo_count`=4, `tx_data_ready`=0, 0x05 dropped. Release `cts` → frames 0x01..0x04 in order, with pointers wrapping correctly on a second fill.
- **CTS mid-frame:** drop `cts` at data bit 3 of 0x55 with a second byte queued → the 0x55 frame completes intact, `tx` then idles high, and the second frame starts one cycle after `cts` returns high.
- **Reset mid-frame:** assert `reset`=0 during data bit 5 → `tx`=1 at that edge, `fifo_count`=0; after release, no residual frame.
